router_pkt_tx: RTL

Packet source for the 1x3 router input port. It buffers payload bytes written by a host, then emits one complete packet per accepted start command on the router's pkt_valid/data bus:
- header byte {payload_len[5:0], dest_addr[1:0]}
- payload_len payload bytes
- one parity byte: XOR of the header and all payload bytes, sent with pkt_valid low.

It honours the router's busy back-pressure and inserts a programmable idle gap between packets.

---
 rtl/router_pkt_tx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx
// Packet source for one router input port. Host-written payload bytes are
// buffered in a circular FIFO. Each accepted start command emits a header
// byte {len,addr}, len payload bytes (pkt_valid=1), then a parity byte
// (pkt_valid=0), followed by GAP_CYCLES idle cycles.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   wr_en, wr_data       host payload writes (dropped while buf_full)
//   buf_full, buf_count  buffer occupancy
//   start, dest_addr,    packet request, sampled only when idle
//   payload_len,
//   corrupt_parity       send the parity byte inverted for this packet
//   busy                 router back-pressure: hold the current byte
//   pkt_valid, data_out  router data bus
//   tx_active            high whenever not idle
//   start_ack/start_err  one-cycle accept / reject pulses
//   pkt_done             one-cycle pulse after the parity byte is taken
module router_pkt_tx #(
  parameter int BUF_DEPTH  = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  output logic                         buf_full,
  output logic [$clog2(BUF_DEPTH):0]   buf_count,
  input  logic                         start,
  input  logic [1:0]                   dest_addr,
  input  logic [5:0]                   payload_len,
  input  logic                         corrupt_parity,
  input  logic                         busy,
  output logic                         pkt_valid,
  output logic [7:0]                   data_out,
  output logic                         tx_active,
  output logic                         start_ack,
  output logic                         start_err,
  output logic                         pkt_done
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    PARITY  = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t          state;
  logic [7:0]      mem [BUF_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [5:0]      len;
  logic [5:0]      sent;
  logic            corrupt;
  logic [7:0]      parity;
  logic [GW-1:0]   gap_cnt;

  logic            wr_ok;
  logic            pop;
  logic            accept;
  logic [7:0]      head_byte;
  logic [7:0]      next_byte;
  logic [7:0]      parity_upd;
  logic [CW-1:0]   count_next;

  always_comb begin
    wr_ok      = wr_en && !buf_full;
    pop        = (state == PAYLOAD) && !busy;
    accept     = (state == IDLE) && start && (dest_addr != 2'd3) &&
                 (buf_count >= CW'(payload_len));
    head_byte  = mem[rd_ptr];
    // data_out is registered, so the byte after the one being popped is
    // fetched one slot ahead; the start-time count check guarantees it exists.
    next_byte  = mem[rd_ptr + AW'(1)];
    parity_upd = parity ^ head_byte;
    count_next = buf_count;
    case ({wr_ok, pop})
      2'b10:   count_next = buf_count + CW'(1);
      2'b01:   count_next = buf_count - CW'(1);
      default: count_next = buf_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
      buf_full  <= 1'b0;
      len       <= '0;
      sent      <= '0;
      corrupt   <= 1'b0;
      parity    <= '0;
      gap_cnt   <= '0;
      pkt_valid <= 1'b0;
      data_out  <= '0;
      tx_active <= 1'b0;
      start_ack <= 1'b0;
      start_err <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      start_ack <= 1'b0;
      start_err <= 1'b0;
      pkt_done  <= 1'b0;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      buf_count <= count_next;
      buf_full  <= (count_next == CW'(BUF_DEPTH));

      case (state)
        IDLE: begin
          if (accept) begin
            len       <= payload_len;
            corrupt   <= corrupt_parity;
            parity    <= {payload_len, dest_addr};
            sent      <= '0;
            state     <= HEADER;
            tx_active <= 1'b1;
            pkt_valid <= 1'b1;
            data_out  <= {payload_len, dest_addr};
            start_ack <= 1'b1;
          end else if (start) begin
            start_err <= 1'b1;
          end
        end
        HEADER: begin
          if (!busy) begin
            if (len == 6'd0) begin
              state     <= PARITY;
              pkt_valid <= 1'b0;
              data_out  <= parity ^ {8{corrupt}};
            end else begin
              state     <= PAYLOAD;
              data_out  <= head_byte;
            end
          end
        end
        PAYLOAD: begin
          if (!busy) begin
            parity <= parity_upd;
            sent   <= sent + 6'd1;
            if (sent == len - 6'd1) begin
              state     <= PARITY;
              pkt_valid <= 1'b0;
              data_out  <= parity_upd ^ {8{corrupt}};
            end else begin
              data_out  <= next_byte;
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            pkt_done <= 1'b1;
            data_out <= '0;
            gap_cnt  <= '0;
            if (GAP_CYCLES == 0) begin
              state     <= IDLE;
              tx_active <= 1'b0;
            end else begin
              state     <= GAP;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state     <= IDLE;
            tx_active <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          tx_active <= 1'b0;
          pkt_valid <= 1'b0;
          data_out  <= '0;
        end
      endcase
    end
  end

endmodule
